mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and default widths for the memory port arbiter
//                (FSM state encoding, grant-owner encoding, default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int c_DEFAULT_BLOCK_WIDTH = 1024;
    localparam int c_DEFAULT_ADDR_WIDTH  = 64;
    localparam int c_DEFAULT_TIMEOUT     = 4096;
    localparam int c_CNT_WIDTH           = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_IC    = 2'd1,
        GRANT_DC_WR = 2'd2,
        GRANT_DC_RD = 2'd3
    } arb_state_t;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin picker. Holds the owner of the
//                last completed transfer; on contention the other one wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_arst,          // active-low, asynchronous
    input  logic   i_req_ic,
    input  logic   i_req_dc,
    input  logic   i_update,
    input  owner_t i_update_owner,
    output logic   o_valid,
    output owner_t o_winner
);

    owner_t r_last;

    // Last-grant pointer: starts at DC so the I-cache wins the first tie
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_last <= DC;
        end else if (i_update) begin
            r_last <= i_update_owner;
        end
    end

    // Pick the winner: lone requester wins, a tie goes to the one not served last
    always_comb begin
        o_valid  = i_req_ic | i_req_dc;
        o_winner = IC;
        if (i_req_ic && i_req_dc) begin
            o_winner = (r_last == IC) ? DC : IC;
        end else if (i_req_dc) begin
            o_winner = DC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates the I-cache and D-cache block transfers onto one
//                downstream transfer unit, with round-robin between caches,
//                writeback-before-refill inside the D-cache, and a sticky
//                per-transfer timeout fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BLOCK_WIDTH = c_DEFAULT_BLOCK_WIDTH,
    parameter int ADDR_WIDTH  = c_DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT     = c_DEFAULT_TIMEOUT
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_ic_read_start,
    input  logic                   i_dc_read_start,
    input  logic                   i_dc_write_start,
    input  logic [ADDR_WIDTH-1:0]  i_ic_addr,
    input  logic [ADDR_WIDTH-1:0]  i_dc_addr,
    input  logic [BLOCK_WIDTH-1:0] i_dc_data_block,
    output logic                   o_ic_done,
    output logic                   o_dc_done,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_start_read,
    output logic                   o_start_write,
    output logic [ADDR_WIDTH-1:0]  o_addr,
    output logic [BLOCK_WIDTH-1:0] o_data_block_mem,
    input  logic                   i_done,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic                   o_timeout
);

    // Counter value seen in the last permitted grant cycle
    localparam logic [c_CNT_WIDTH-1:0] c_TIMEOUT_LAST = c_CNT_WIDTH'(TIMEOUT - 1);

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    arb_state_t             r_state;
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic                   r_timeout;

    logic   w_ic_req;
    logic   w_dc_req;
    logic   w_grant_valid;
    owner_t w_grant_owner;
    logic   w_in_grant;
    logic   w_granted_level;
    logic   w_done_accept;
    owner_t w_done_owner;

    // Reset synchroniser: asserts immediately, releases two edges later, so no
    // request can be granted in the first cycle after i_arst rises
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_ic_req      = i_ic_read_start;
    assign w_dc_req      = i_dc_read_start | i_dc_write_start;
    assign w_in_grant    = (r_state != IDLE);
    assign w_done_accept = w_in_grant & i_done;
    assign w_done_owner  = (r_state == GRANT_IC) ? IC : DC;

    rr_arbiter2 u_rr_arbiter2 (
        .i_clk          (i_clk),
        .i_arst         (w_rst_n),
        .i_req_ic       (w_ic_req),
        .i_req_dc       (w_dc_req),
        .i_update       (w_done_accept),
        .i_update_owner (w_done_owner),
        .o_valid        (w_grant_valid),
        .o_winner       (w_grant_owner)
    );

    // Level of the request that owns the current grant
    always_comb begin
        w_granted_level = 1'b0;
        case (r_state)
            GRANT_IC:    w_granted_level = i_ic_read_start;
            GRANT_DC_WR: w_granted_level = i_dc_write_start;
            GRANT_DC_RD: w_granted_level = i_dc_read_start;
            default:     w_granted_level = 1'b0;
        endcase
    end

    // Grant FSM: pick in IDLE, leave a grant on done, abandon or timeout
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_cnt <= '0;
                        if (w_grant_owner == IC) begin
                            r_state <= GRANT_IC;
                        end else if (i_dc_write_start) begin
                            r_state <= GRANT_DC_WR;   // writeback before refill
                        end else begin
                            r_state <= GRANT_DC_RD;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_done || !w_granted_level) begin
                        r_state <= IDLE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
            endcase
        end
    end

    // Downstream requests, address/data mux and per-requester done pulses
    always_comb begin
        o_start_read     = 1'b0;
        o_start_write    = 1'b0;
        o_addr           = '0;
        o_data_block_mem = '0;
        o_ic_done        = 1'b0;
        o_dc_done        = 1'b0;
        case (r_state)
            GRANT_IC: begin
                o_start_read     = i_ic_read_start;
                o_addr           = i_ic_addr;
                o_data_block_mem = i_dc_data_block;
                o_ic_done        = i_done;
            end
            GRANT_DC_WR: begin
                o_start_write    = i_dc_write_start;
                o_addr           = i_dc_addr;
                o_data_block_mem = i_dc_data_block;
                o_dc_done        = i_done;
            end
            GRANT_DC_RD: begin
                o_start_read     = i_dc_read_start;
                o_addr           = i_dc_addr;
                o_data_block_mem = i_dc_data_block;
                o_dc_done        = i_done;
            end
            default: begin
                o_start_read = 1'b0;
            end
        endcase
    end

    assign o_data_block = i_data_block;
    assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed scenarios
//                with literal expectations, then randomized traffic compared
//                every cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int BW  = 64;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          ic_rd = 1'b0, dc_rd = 1'b0, dc_wr = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic [BW-1:0] dc_data = '0, mem_data = '0;
    logic          done_in = 1'b0;

    logic          ic_done, dc_done, start_read, start_write, timeout;
    logic [AW-1:0] addr;
    logic [BW-1:0] blk_out, mem_wdata;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: who owns the port (0 none, 1 IC read, 2 DC write,
    // 3 DC read), who finished last, cycles spent in the current grant
    int owner   = 0;
    bit last_dc = 1'b1;
    int held    = 0;
    bit tmo     = 1'b0;
    int sync    = 0;
    bit ic_fin = 1'b0, dcw_fin = 1'b0, dcr_fin = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .BLOCK_WIDTH (BW),
        .ADDR_WIDTH  (AW),
        .TIMEOUT     (TMO)
    ) dut (
        .i_clk            (clk),
        .i_arst           (arst),
        .i_ic_read_start  (ic_rd),
        .i_dc_read_start  (dc_rd),
        .i_dc_write_start (dc_wr),
        .i_ic_addr        (ic_addr),
        .i_dc_addr        (dc_addr),
        .i_dc_data_block  (dc_data),
        .o_ic_done        (ic_done),
        .o_dc_done        (dc_done),
        .o_data_block     (blk_out),
        .o_start_read     (start_read),
        .o_start_write    (start_write),
        .o_addr           (addr),
        .o_data_block_mem (mem_wdata),
        .i_done           (done_in),
        .i_data_block     (mem_data),
        .o_timeout        (timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update at each clock edge (reset is asynchronous)
    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            owner = 0; last_dc = 1'b1; held = 0; tmo = 1'b0; sync = 0;
            ic_fin = 1'b0; dcw_fin = 1'b0; dcr_fin = 1'b0;
        end else begin
            ic_fin  = (owner == 1) && done_in;
            dcw_fin = (owner == 2) && done_in;
            dcr_fin = (owner == 3) && done_in;
            if (sync < 2) begin
                sync++;
            end else if (owner == 0) begin
                held = 0;
                if (ic_rd && (!(dc_rd || dc_wr) || last_dc)) owner = 1;
                else if (dc_wr) owner = 2;
                else if (dc_rd) owner = 3;
            end else begin
                bit lvl;
                lvl = (owner == 1) ? ic_rd : (owner == 2) ? dc_wr : dc_rd;
                held++;
                if (done_in) begin
                    last_dc = (owner != 1);
                    owner   = 0;
                end else if (!lvl) begin
                    owner = 0;
                end else if (held == TMO) begin
                    tmo   = 1'b1;
                    owner = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ic_done",     ic_done,     (owner == 1) && done_in);
            chk("dc_done",     dc_done,     (owner >= 2) && done_in);
            chk("start_read",  start_read,  (owner == 1) ? ic_rd : (owner == 3) ? dc_rd : 1'b0);
            chk("start_write", start_write, (owner == 2) ? dc_wr : 1'b0);
            chk("addr",        addr,        (owner == 1) ? ic_addr : (owner != 0) ? dc_addr : '0);
            chk("wdata_mem",   mem_wdata,   (owner != 0) ? dc_data : '0);
            chk("data_block",  blk_out,     mem_data);
            chk("timeout",     timeout,     tmo);
        end
    end

    initial begin
        #2 arst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_start_read",  start_read,  0);
        chk("rst_start_write", start_write, 0);
        chk("rst_timeout",     timeout,     0);
        chk("rst_ic_done",     ic_done,     0);
        tick(); arst = 1'b1;
        repeat (3) tick();

        // Lone I-cache read at 0x1000
        ic_rd = 1'b1; ic_addr = 32'h1000;
        @(negedge clk); chk("lone_idle_start", start_read, 0);
        tick(); @(negedge clk);
        chk("lone_start_read", start_read, 1);
        chk("lone_addr",       addr,       32'h1000);
        repeat (9) tick();
        tick(); done_in = 1'b1;
        @(negedge clk); chk("lone_ic_done", ic_done, 1); chk("lone_dc_done", dc_done, 0);
        tick(); done_in = 1'b0; ic_rd = 1'b0;
        @(negedge clk); chk("lone_done_pulse", ic_done, 0); chk("lone_back_idle", start_read, 0);

        // Collision after reset: IC first, then alternation
        tick(); arst = 1'b0;
        tick(); arst = 1'b1;
        repeat (3) tick();
        ic_rd = 1'b1; ic_addr = 32'h2000; dc_rd = 1'b1; dc_addr = 32'h3000;
        tick(); @(negedge clk); chk("coll1_addr", addr, 32'h2000);
        tick(); done_in = 1'b1;
        @(negedge clk); chk("coll1_ic_done", ic_done, 1); chk("coll1_dc_done", dc_done, 0);
        tick(); done_in = 1'b0; ic_rd = 1'b0; dc_rd = 1'b0;
        tick(); ic_rd = 1'b1; ic_addr = 32'h2100; dc_rd = 1'b1; dc_addr = 32'h3100;
        tick(); @(negedge clk); chk("coll2_addr_dc", addr, 32'h3100);
        tick(); done_in = 1'b1;
        @(negedge clk); chk("coll2_dc_done", dc_done, 1);
        tick(); done_in = 1'b0; dc_rd = 1'b0;
        tick(); @(negedge clk); chk("coll3_addr_ic", addr, 32'h2100);
        tick(); done_in = 1'b1;
        tick(); done_in = 1'b0; ic_rd = 1'b0;
        tick();

        // D-cache write and read together: writeback first
        dc_wr = 1'b1; dc_rd = 1'b1; dc_addr = 32'h4000; dc_data = 64'hA5A5_A5A5_A5A5_A5A5;
        tick(); @(negedge clk);
        chk("wr_first_start_write", start_write, 1);
        chk("wr_first_start_read",  start_read,  0);
        chk("wr_first_wdata",       mem_wdata,   64'hA5A5_A5A5_A5A5_A5A5);
        tick(); done_in = 1'b1;
        @(negedge clk); chk("wr_done", dc_done, 1);
        tick(); done_in = 1'b0; dc_wr = 1'b0;
        @(negedge clk); chk("wr_idle_read", start_read, 0);
        tick(); @(negedge clk); chk("rd_after_wr", start_read, 1); chk("rd_after_wr_w", start_write, 0);

        // Reset mid-transfer, then regrant of the pending read
        tick(); arst = 1'b0;
        @(negedge clk); chk("midrst_start_read", start_read, 0); chk("midrst_addr", addr, 0);
        tick(); arst = 1'b1;
        tick(); @(negedge clk); chk("rel_no_grant1", start_read, 0);
        tick(); @(negedge clk); chk("rel_no_grant2", start_read, 0);
        tick(); @(negedge clk); chk("rel_regrant", start_read, 1); chk("rel_regrant_addr", addr, 32'h4000);

        // Requester drops mid-grant; other requester served afterwards
        tick(); dc_rd = 1'b0; ic_rd = 1'b1; ic_addr = 32'h5000;
        @(negedge clk); chk("drop_no_done", dc_done, 0); chk("drop_start", start_read, 0);
        tick(); @(negedge clk); chk("drop_idle", start_read, 0);
        tick(); @(negedge clk); chk("drop_other_grant", start_read, 1); chk("drop_other_addr", addr, 32'h5000);

        // Timeout: no done for TMO grant cycles
        repeat (TMO - 2) tick();
        tick(); @(negedge clk); chk("tmo_last_cycle", timeout, 0); chk("tmo_last_start", start_read, 1);
        tick(); ic_rd = 1'b0;
        @(negedge clk); chk("tmo_set", timeout, 1); chk("tmo_idle", start_read, 0);
        repeat (3) tick();
        @(negedge clk); chk("tmo_sticky", timeout, 1);
        tick(); arst = 1'b0;
        @(negedge clk); chk("tmo_cleared", timeout, 0);
        tick(); arst = 1'b1;
        repeat (3) tick();

        // Randomized traffic, checked by the model every cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int done_pct;
            tick();
            done_pct = (cyc < 1500) ? 25 : 4;
            if (ic_rd) begin
                if (ic_fin || $urandom_range(0, 99) < 3) ic_rd = 1'b0;
            end else if ($urandom_range(0, 99) < 30) begin
                ic_rd = 1'b1; ic_addr = $urandom;
            end
            if (dc_wr) begin
                if (dcw_fin || $urandom_range(0, 99) < 3) dc_wr = 1'b0;
            end else if ($urandom_range(0, 99) < 20) begin
                if (!dc_rd) dc_addr = $urandom;
                dc_data = {$urandom, $urandom};
                dc_wr = 1'b1;
            end
            if (dc_rd) begin
                if (dcr_fin || $urandom_range(0, 99) < 3) dc_rd = 1'b0;
            end else if ($urandom_range(0, 99) < 25) begin
                if (!dc_wr) dc_addr = $urandom;
                dc_rd = 1'b1;
            end
            done_in  = ($urandom_range(0, 99) < done_pct);
            mem_data = {$urandom, $urandom};
            if (!arst) arst = 1'b1;
            else if ($urandom_range(0, 399) == 0) arst = 1'b0;
        end

        tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
